// File: rtl/data_mem_stage.sv
// Multi-cycle data memory stage: 32x32 array behind an IDLE/WAIT/DONE handshake.
// Define DMEM_FAULT_EN to flag misaligned or out-of-range addresses instead of aliasing them.
module data_mem_stage #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        busy,
    output logic        done,
    output logic        addrFault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_write;
    logic [4:0]  r_index;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_mem [32];
    logic [31:0] r_read_data;
    logic        r_busy;
    logic        r_done;
    logic        r_addr_fault;
    logic        w_fault;

`ifdef DMEM_FAULT_EN
    assign w_fault = (address[1:0] != 2'b00) || (address[31:7] != 25'd0);
`else
    // Only address[6:2] selects a word; the remaining bits alias.
    logic w_unused_addr;
    assign w_unused_addr = ^{address[31:7], address[1:0]};
    assign w_fault       = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_is_write   <= 1'b0;
            r_index      <= 5'd0;
            r_wdata      <= 32'd0;
            r_fault      <= 1'b0;
            r_read_data  <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr_fault <= 1'b0;
            // NOTE: clearing the array on reset maps it to flops, not a RAM macro; it is small enough.
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_done       <= 1'b0;
            r_addr_fault <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (memRead || memWrite) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= LAT;
                        r_busy     <= 1'b1;
                        r_is_write <= memWrite;
                        r_index    <= address[6:2];
                        r_wdata    <= writeData;
                        r_fault    <= w_fault;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_addr_fault <= r_fault;
                        if (!r_fault) begin
                            if (r_is_write) begin
                                r_mem[r_index] <= r_wdata;
                            end else begin
                                r_read_data <= r_mem[r_index];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign readData  = r_read_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign addrFault = r_addr_fault;

endmodule
